// File: rtl/legv8_pkg.sv
// Shared LEGv8 run-control definitions: state encodings, halt idiom and default widths.
package legv8_pkg;

    localparam int unsigned LEGV8_PC_WIDTH    = 64;
    localparam int unsigned LEGV8_INSTR_WIDTH = 32;

    // B #0: unconditional branch to self, used by programs to signal completion
    localparam logic [31:0] LEGV8_HALT_B0 = 32'h1400_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_e;

    function automatic logic st_is_done(input run_state_e s);
        return (s == ST_HALTED) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/legv8_trace_fifo.sv
// Synchronous trace FIFO with registered show-ahead head, flush, and sticky drop-on-full flag.
module legv8_trace_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full_c,
    output logic             o_overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr, r_wr_ptr, w_rd_nxt, w_wr_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic [WIDTH-1:0] r_head, w_head_nxt;
    logic             r_valid, r_overflow, w_overflow_nxt;
    logic             w_empty, w_do_push, w_do_pop;

    assign w_empty   = (r_count == '0);
    assign o_full_c  = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!o_full_c || w_do_pop);

    // Pointer/count update and next head; a push landing on the new read slot bypasses storage
    always_comb begin
        w_rd_nxt       = r_rd_ptr;
        w_wr_nxt       = r_wr_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_head_nxt     = '0;
        if (i_flush) begin
            w_rd_nxt       = '0;
            w_wr_nxt       = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            if (w_do_pop)  w_rd_nxt = r_rd_ptr + 1'b1;
            if (w_do_push) w_wr_nxt = r_wr_ptr + 1'b1;
            w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);
            if (i_push && !w_do_push) w_overflow_nxt = 1'b1;
        end
        if (w_count_nxt != '0) begin
            w_head_nxt = (w_do_push && (r_wr_ptr == w_rd_nxt)) ? i_data : r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_head     <= '0;
        end else begin
            r_rd_ptr   <= w_rd_nxt;
            r_wr_ptr   <= w_wr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
            r_valid    <= (w_count_nxt != '0);
            r_head     <= w_head_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_valid    = r_valid;
    assign o_head     = r_head;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/legv8_run_ctrl.sv
// LEGv8 run control: start/abort/clear FSM, saturating counters, halt and cycle-limit detection.
// Retired-PC trace FIFO is built only when LEGV8_RUN_CTRL_TRACE_EN is defined.
module legv8_run_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned            PC_WIDTH    = LEGV8_PC_WIDTH,
    parameter int unsigned            INSTR_WIDTH = LEGV8_INSTR_WIDTH,
    parameter int unsigned            CNT_WIDTH   = 32,
    parameter int unsigned            TRACE_DEPTH = 16,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = INSTR_WIDTH'(LEGV8_HALT_B0)
) (
    input  logic                   CLK,
    input  logic                   RESET_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   clear,
    input  logic [CNT_WIDTH-1:0]   cycle_limit,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instruction_word,
    input  logic                   retire_valid,
    output logic                   core_run,
    output logic [1:0]             state,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    output logic [CNT_WIDTH-1:0]   instr_count,
    input  logic                   trace_rd_en,
    output logic                   trace_valid,
    output logic [PC_WIDTH-1:0]    trace_pc,
    output logic                   trace_overflow
);

    run_state_e           r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cycle_cnt, w_cycle_nxt;
    logic [CNT_WIDTH-1:0] r_instr_cnt, w_instr_nxt;
    logic [CNT_WIDTH-1:0] r_limit, w_limit_nxt;
    logic                 r_core_run, r_done;
    logic                 w_push, w_flush;

    // Abort beats halt, halt beats timeout; the halt instruction itself is counted
    always_comb begin
        w_state_nxt = r_state;
        w_cycle_nxt = r_cycle_cnt;
        w_instr_nxt = r_instr_cnt;
        w_limit_nxt = r_limit;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_cycle_nxt = '0;
                    w_instr_nxt = '0;
                    w_limit_nxt = cycle_limit;
                    w_flush     = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_push      = retire_valid;
                    w_cycle_nxt = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + 1'b1;
                    if (retire_valid && !(&r_instr_cnt)) w_instr_nxt = r_instr_cnt + 1'b1;
                    if (retire_valid && (instruction_word == HALT_INSTR)) begin
                        w_state_nxt = ST_HALTED;
                    end else if ((r_limit != '0) &&
                                 (CNT_WIDTH'(r_cycle_cnt + 1'b1) == r_limit)) begin
                        w_state_nxt = ST_TIMEOUT;
                    end
                end
            end
            ST_HALTED, ST_TIMEOUT: begin
                if (clear) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= ST_IDLE;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_limit     <= '0;
            r_core_run  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cycle_cnt <= w_cycle_nxt;
            r_instr_cnt <= w_instr_nxt;
            r_limit     <= w_limit_nxt;
            r_core_run  <= (w_state_nxt == ST_RUN);
            r_done      <= st_is_done(w_state_nxt);
        end
    end

    assign state       = r_state;
    assign core_run    = r_core_run;
    assign done        = r_done;
    assign cycle_count = r_cycle_cnt;
    assign instr_count = r_instr_cnt;

`ifdef LEGV8_RUN_CTRL_TRACE_EN
    logic w_unused_fifo_full;

    legv8_trace_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .i_clk      (CLK),
        .i_rst_n    (RESET_n),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_data     (pc),
        .i_pop      (trace_rd_en),
        .o_valid    (trace_valid),
        .o_head     (trace_pc),
        .o_full_c   (w_unused_fifo_full),
        .o_overflow (trace_overflow)
    );
`else
    logic w_unused_trace;
    assign w_unused_trace = ^{pc, trace_rd_en, w_push, w_flush, TRACE_DEPTH[0]};
    assign trace_valid    = 1'b0;
    assign trace_pc       = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_legv8_run_ctrl.sv
// Self-checking bench for legv8_run_ctrl: directed scenarios plus random traffic against a queue model.
module tb_legv8_run_ctrl;

    localparam int unsigned CW    = 6;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] HALT  = 32'h1400_0000;
    localparam longint      CMAX  = (longint'(1) << CW) - 1;

    logic          CLK = 1'b0;
    logic          RESET_n, start, abort, clear, retire_valid, trace_rd_en;
    logic [CW-1:0] cycle_limit;
    logic [63:0]   pc;
    logic [31:0]   instruction_word;
    logic          core_run, done, trace_valid, trace_overflow;
    logic [1:0]    state;
    logic [CW-1:0] cycle_count, instr_count;
    logic [63:0]   trace_pc;

    always #5 CLK = ~CLK;

    legv8_run_ctrl #(.CNT_WIDTH(CW), .TRACE_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .start(start), .abort(abort), .clear(clear),
        .cycle_limit(cycle_limit), .pc(pc), .instruction_word(instruction_word),
        .retire_valid(retire_valid), .core_run(core_run), .state(state), .done(done),
        .cycle_count(cycle_count), .instr_count(instr_count), .trace_rd_en(trace_rd_en),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_overflow(trace_overflow)
    );

    // Reference model: state as 0..3, counters as plain integers, trace as a queue
    int          m_state;
    longint      m_cyc, m_instr, m_lim;
    logic [63:0] m_q[$];
    bit          m_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cyc = 0; m_instr = 0; m_lim = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_update();
        bit run_retire;
        run_retire = (m_state == 1) && !abort && retire_valid;
        if (m_state == 0 && start) begin
            m_q.delete();
            m_ovf = 0;
        end else begin
            if (trace_rd_en && m_q.size() > 0) void'(m_q.pop_front());
            if (run_retire) begin
                if (m_q.size() < DEPTH) m_q.push_back(pc);
                else m_ovf = 1;
            end
        end
        case (m_state)
            0: if (start) begin
                m_state = 1; m_cyc = 0; m_instr = 0; m_lim = longint'(cycle_limit);
            end
            1: if (abort) m_state = 0;
               else begin
                   if (m_cyc < CMAX) m_cyc++;
                   if (retire_valid && m_instr < CMAX) m_instr++;
                   if (retire_valid && instruction_word == HALT) m_state = 2;
                   else if (m_lim != 0 && m_cyc == m_lim) m_state = 3;
               end
            default: if (clear) m_state = 0;
        endcase
    endtask

    task automatic check_all(input string ph);
        bit          e_valid, e_ovf;
        logic [63:0] e_head;
`ifdef LEGV8_RUN_CTRL_TRACE_EN
        e_valid = (m_q.size() > 0);
        e_head  = e_valid ? m_q[0] : 64'd0;
        e_ovf   = m_ovf;
`else
        e_valid = 0; e_head = 64'd0; e_ovf = 0;
`endif
        chk({ph, ".state"},    64'(state),          64'(m_state));
        chk({ph, ".core_run"}, 64'(core_run),       64'(m_state == 1));
        chk({ph, ".done"},     64'(done),           64'(m_state >= 2));
        chk({ph, ".cycles"},   64'(cycle_count),    64'(m_cyc));
        chk({ph, ".instrs"},   64'(instr_count),    64'(m_instr));
        chk({ph, ".tvalid"},   64'(trace_valid),    64'(e_valid));
        chk({ph, ".tpc"},      trace_pc,            e_head);
        chk({ph, ".tovf"},     64'(trace_overflow), 64'(e_ovf));
    endtask

    task automatic cycle(input string ph);
        @(posedge CLK);
        if (!RESET_n) model_reset();
        else model_update();
        #1;
        check_all(ph);
    endtask

    function automatic logic [31:0] rand_iw();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v = v ^ 32'h1;
        return v;
    endfunction

    initial begin
        int popped;
        RESET_n = 1'b1; start = 0; abort = 0; clear = 0; cycle_limit = '0;
        pc = '0; instruction_word = '0; retire_valid = 0; trace_rd_en = 0;
        model_reset();
        #1 RESET_n = 1'b0;
        #1 check_all("reset");
        repeat (2) cycle("reset");
        @(negedge CLK) RESET_n = 1'b1;

        // Scenario 1: five retires then B #0 at 0x14
        cycle_limit = '0; start = 1; cycle("s1_start"); start = 0;
        for (int i = 0; i < 6; i++) begin
            retire_valid = 1; pc = 64'(4 * i);
            instruction_word = (i == 5) ? HALT : rand_iw();
            cycle("s1_run");
        end
        retire_valid = 0;
        chk("s1_state_halted", 64'(state), 64'd2);
        chk("s1_instr_count", 64'(instr_count), 64'd6);
        chk("s1_cycle_count", 64'(cycle_count), 64'd6);
        chk("s1_core_run_low", 64'(core_run), 64'd0);
        start = 1; cycle("s1_start_ignored"); start = 0;
        chk("s1_start_ignored", 64'(state), 64'd2);
`ifdef LEGV8_RUN_CTRL_TRACE_EN
        for (int i = 0; i < 6; i++) begin
            chk("s1_trace_pc", trace_pc, 64'(4 * i));
            trace_rd_en = 1; cycle("s1_pop");
        end
        trace_rd_en = 0;
        chk("s1_trace_drained", 64'(trace_valid), 64'd0);
`else
        repeat (6) begin trace_rd_en = 1; cycle("s1_pop"); end
        trace_rd_en = 0;
        chk("s1_no_trace", 64'(trace_valid), 64'd0);
`endif
        clear = 1; cycle("s1_clear"); clear = 0;
        chk("s1_cleared", 64'(state), 64'd0);

        // Scenario 2: limit 8, never halt; limit input changes after start must not matter
        cycle_limit = CW'(8); start = 1; cycle("s2_start"); start = 0; cycle_limit = '0;
        repeat (8) begin
            retire_valid = 1'($urandom_range(0, 1)); pc = {$urandom, $urandom};
            instruction_word = rand_iw(); trace_rd_en = 1'($urandom_range(0, 1));
            cycle("s2_run");
        end
        retire_valid = 0; trace_rd_en = 0;
        chk("s2_state_timeout", 64'(state), 64'd3);
        chk("s2_cycle_count", 64'(cycle_count), 64'd8);
        chk("s2_done", 64'(done), 64'd1);
        abort = 1; cycle("s2_abort_ignored"); abort = 0;
        chk("s2_abort_ignored", 64'(state), 64'd3);
        clear = 1; cycle("s2_clear"); clear = 0;
        cycle_limit = CW'(6); start = 1; cycle("s3_start"); start = 0;
        chk("s2_restart_cycles", 64'(cycle_count), 64'd0);
        chk("s2_restart_instrs", 64'(instr_count), 64'd0);

        // Scenario 3: halt and timeout on the same edge
        repeat (5) begin
            retire_valid = 1'($urandom_range(0, 1)); pc = {$urandom, $urandom};
            instruction_word = rand_iw(); cycle("s3_run");
        end
        retire_valid = 1; instruction_word = HALT; cycle("s3_halt");
        retire_valid = 0;
        chk("s3_halt_wins", 64'(state), 64'd2);
        chk("s3_cycle_count", 64'(cycle_count), 64'd6);
        clear = 1; cycle("s3_clear"); clear = 0;

        // Scenario 4: overflow, push+pop while full, abort holding counters, drain
        cycle_limit = '0; start = 1; cycle("s4_start"); start = 0;
        for (int i = 0; i < 20; i++) begin
            retire_valid = 1; pc = 64'h100 + 64'(4 * i); instruction_word = rand_iw();
            cycle("s4_fill");
        end
`ifdef LEGV8_RUN_CTRL_TRACE_EN
        chk("s4_overflow", 64'(trace_overflow), 64'd1);
        chk("s4_head_first", trace_pc, 64'h100);
`else
        chk("s4_no_overflow", 64'(trace_overflow), 64'd0);
`endif
        pc = 64'h200; trace_rd_en = 1; cycle("s4_push_pop");
        retire_valid = 0; trace_rd_en = 0;
`ifdef LEGV8_RUN_CTRL_TRACE_EN
        chk("s4_head_after_pp", trace_pc, 64'h104);
`endif
        abort = 1; cycle("s4_abort"); abort = 0;
        chk("s4_abort_idle", 64'(state), 64'd0);
        chk("s4_abort_cycles", 64'(cycle_count), 64'd21);
        chk("s4_abort_instrs", 64'(instr_count), 64'd21);
        popped = 0;
        for (int k = 0; k < 40 && trace_valid; k++) begin
            trace_rd_en = 1; cycle("s4_drain"); popped++;
        end
        trace_rd_en = 0;
`ifdef LEGV8_RUN_CTRL_TRACE_EN
        chk("s4_entries_kept", 64'(popped), 64'd16);
`else
        chk("s4_entries_kept", 64'(popped), 64'd0);
`endif

        // Abort has priority over a halt retiring on the same cycle
        start = 1; cycle("s4b_start"); start = 0;
        retire_valid = 1; instruction_word = HALT; abort = 1; cycle("s4b_abort_halt");
        retire_valid = 0; abort = 0;
        chk("s4b_abort_over_halt", 64'(state), 64'd0);
        chk("s4b_instr_held", 64'(instr_count), 64'd0);

        // Scenario 5: asynchronous reset during RUN
        start = 1; cycle("s5_start"); start = 0;
        repeat (3) begin
            retire_valid = 1; pc = {$urandom, $urandom}; instruction_word = rand_iw();
            cycle("s5_run");
        end
        retire_valid = 0;
        #2 RESET_n = 1'b0;
        #1 model_reset();
        check_all("s5_async_reset");
        chk("s5_core_run_zero", 64'(core_run), 64'd0);
        chk("s5_cycles_zero", 64'(cycle_count), 64'd0);
        cycle("s5_in_reset");
        @(negedge CLK) RESET_n = 1'b1;

        // Counter saturation at all-ones
        cycle_limit = '0; start = 1; cycle("sat_start"); start = 0;
        repeat (70) begin
            retire_valid = 1; pc = {$urandom, $urandom}; instruction_word = rand_iw();
            trace_rd_en = 1'($urandom_range(0, 1)); cycle("sat_run");
        end
        retire_valid = 0; trace_rd_en = 0;
        chk("sat_cycles", 64'(cycle_count), 64'(CMAX));
        chk("sat_instrs", 64'(instr_count), 64'(CMAX));
        abort = 1; cycle("sat_abort"); abort = 0;

        // Random traffic against the model
        repeat (400) begin
            start            = ($urandom_range(0, 3) == 0);
            abort            = ($urandom_range(0, 15) == 0);
            clear            = ($urandom_range(0, 3) == 0);
            cycle_limit      = CW'($urandom_range(0, 20));
            retire_valid     = 1'($urandom_range(0, 1));
            pc               = {$urandom, $urandom};
            instruction_word = ($urandom_range(0, 9) == 0) ? HALT : rand_iw();
            trace_rd_en      = ($urandom_range(0, 2) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
